clkgen_rst_seq: RTL



---
 rtl/clkgen_pkg.sv | 13 +
 rtl/clkgen_sync.sv | 23 ++
 rtl/clkgen_rst_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package clkgen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/clkgen_sync.sv
// N-flop level synchroniser; clears to 0 so an unsynchronised input reads as "not ok".
module clkgen_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clkgen_rst_seq.sv
// Reset sequencer: filters PLL lock, stretches reset, releases channels staggered,
// drops all channels on lock/button loss, and adds per-channel software pulses.
module clkgen_rst_seq
  import clkgen_pkg::*;
#(
  parameter int NUM_RST        = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int LOCK_FILTER    = 4,
  parameter int STRETCH_CYCLES = 8,
  parameter int STAGGER_CYCLES = 2,
  parameter int SW_PULSE       = 5
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  pll_locked_i,
  input  logic                  ext_rst_ni,
  input  logic [NUM_RST-1:0]    sw_rst_req_i,
  output logic [NUM_RST-1:0]    rst_n_o,
  output logic                  ready_o,
  output logic [LOSS_CNT_W-1:0] loss_cnt_o
);

  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int STR_W  = $clog2(STRETCH_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int PLS_W  = $clog2(SW_PULSE + 1);
  localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(LOCK_FILTER);
  localparam logic [STR_W-1:0]  STR_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [STG_W-1:0]  STG_LAST = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_RST - 1);
  localparam logic [PLS_W-1:0]  PLS_LEN  = PLS_W'(SW_PULSE);

  logic lock_s, ext_s, ok;

  clkgen_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i (clk_sys),
    .rst_ni(rst_sys_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  clkgen_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk_i (clk_sys),
    .rst_ni(rst_sys_n),
    .d_i   (ext_rst_ni),
    .q_o   (ext_s)
  );

  assign ok = lock_s & ext_s;

  state_e                  state_q, state_d;
  logic [FILT_W-1:0]       filt_q, filt_d;
  logic [STR_W-1:0]        str_q, str_d;
  logic [STG_W-1:0]        stg_q, stg_d;
  logic [IDX_W-1:0]        idx_q, idx_d, idx_nxt;
  logic [NUM_RST-1:0]      rel_q, rel_d;
  logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
  logic [NUM_RST-1:0]      rst_n_q, pulse_d;
  logic                    ready_q;
  logic                    flush;

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    str_d   = str_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    rel_d   = rel_q;
    loss_d  = loss_q;
    flush   = 1'b0;
    idx_nxt = idx_q + 1'b1;
    // Loss outside WAIT_LOCK wins over every sequencing step.
    if (state_q != WAIT_LOCK && !ok) begin
      flush   = 1'b1;
      state_d = WAIT_LOCK;
      filt_d  = '0;
      rel_d   = '0;
      if (!lock_s && (state_q == RELEASE || state_q == RUN) && loss_q != '1) begin
        loss_d = loss_q + 1'b1;
      end
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!ok) begin
            filt_d = '0;
          end else if (filt_q == FILT_MAX) begin
            state_d = STRETCH;
            filt_d  = '0;
            str_d   = '0;
          end else begin
            filt_d = filt_q + 1'b1;
          end
        end
        STRETCH: begin
          if (str_q == STR_LAST) begin
            state_d  = (NUM_RST == 1) ? RUN : RELEASE;
            rel_d[0] = 1'b1;
            idx_d    = '0;
            stg_d    = '0;
          end else begin
            str_d = str_q + 1'b1;
          end
        end
        RELEASE: begin
          if (stg_q == STG_LAST) begin
            stg_d          = '0;
            idx_d          = idx_nxt;
            rel_d[idx_nxt] = 1'b1;
            if (idx_nxt == IDX_LAST) state_d = RUN;
          end else begin
            stg_d = stg_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-channel software pulse: counter holds remaining low cycles.
  for (genvar k = 0; k < NUM_RST; k++) begin : g_pulse
    logic [PLS_W-1:0] pcnt_q, pcnt_d;

    always_comb begin
      pcnt_d = pcnt_q;
      if (flush) begin
        pcnt_d = '0;
      end else if (pcnt_q != '0) begin
        pcnt_d = pcnt_q - 1'b1;
      end else if (state_q == RUN && sw_rst_req_i[k]) begin
        pcnt_d = PLS_LEN;
      end
    end

    assign pulse_d[k] = (pcnt_d != '0);

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
      if (!rst_sys_n) pcnt_q <= '0;
      else            pcnt_q <= pcnt_d;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= WAIT_LOCK;
      filt_q  <= '0;
      str_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rel_q   <= '0;
      loss_q  <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      str_q   <= str_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rel_q   <= rel_d;
      loss_q  <= loss_d;
      rst_n_q <= rel_d & ~pulse_d;
      ready_q <= (state_d == RUN);
    end
  end

  assign rst_n_o    = rst_n_q;
  assign ready_o    = ready_q;
  assign loss_cnt_o = loss_q;

endmodule
